// File: rtl/mm_regbank.sv
// Avalon-MM register bank: NREGS byte-writable control words, a free-running
// cycle counter and a sticky write-1-to-clear status capture register.
module mm_regbank #(
    parameter int          NREGS          = 4,
    parameter int          STATUS_WIDTH   = 8,
    parameter logic [31:0] UNMAPPED_VALUE = 32'hDEADBEEF
) (
    input  logic                      clk_clk,
    input  logic                      reset_reset_n,
    input  logic [31:0]               address,
    input  logic                      read,
    input  logic                      write,
    input  logic [3:0]                byteenable,
    input  logic [31:0]               writedata,
    output logic [31:0]               readdata,
    output logic                      readdatavalid,
    output logic                      waitrequest,
    input  logic [STATUS_WIDTH-1:0]   status_in,
    output logic [32*NREGS-1:0]       ctrl_out,
    output logic [NREGS-1:0]          wr_strobe
);

    localparam logic [29:0] IDX_CYCLES = 30'(NREGS);
    localparam logic [29:0] IDX_STICKY = 30'(NREGS + 1);

    logic [29:0]             word_idx;
    logic [1:0]              unused_addr_lsb;

    logic [31:0]             ctrl_q [NREGS];
    logic [31:0]             ctrl_d [NREGS];
    logic [31:0]             cycles_q, cycles_d, cycles_inc;
    logic [STATUS_WIDTH-1:0] sticky_q, sticky_d;
    logic [31:0]             rdata_q, rdata_d;
    logic                    rvalid_q, rvalid_d;
    logic [NREGS-1:0]        strobe_q, strobe_d;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  be);
        logic [31:0] res;
        for (int k = 0; k < 4; k++) begin
            res[8*k +: 8] = be[k] ? new_val[8*k +: 8] : old_val[8*k +: 8];
        end
        return res;
    endfunction

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        logic [31:0] m;
        for (int k = 0; k < 4; k++) begin
            m[8*k +: 8] = {8{be[k]}};
        end
        return m;
    endfunction

    assign word_idx        = address[31:2];
    assign unused_addr_lsb = address[1:0];
    assign waitrequest     = 1'b0;
    assign cycles_inc      = cycles_q + 32'd1;

    always_comb begin
        ctrl_d   = ctrl_q;
        strobe_d = '0;
        cycles_d = cycles_inc;
        sticky_d = sticky_q;
        rvalid_d = read;

        if (write) begin
            for (int i = 0; i < NREGS; i++) begin
                if (word_idx == 30'(i)) begin
                    ctrl_d[i]   = merge_bytes(ctrl_q[i], writedata, byteenable);
                    strobe_d[i] = 1'b1;
                end
            end
            if (word_idx == IDX_CYCLES) begin
                cycles_d = merge_bytes(cycles_inc, writedata, byteenable);
            end
            if (word_idx == IDX_STICKY) begin
                sticky_d = sticky_q & ~STATUS_WIDTH'(writedata & lane_mask(byteenable));
            end
        end
        // Capture is applied after the clear so a same-cycle set wins.
        sticky_d = sticky_d | status_in;

        rdata_d = UNMAPPED_VALUE;
        for (int i = 0; i < NREGS; i++) begin
            if (word_idx == 30'(i)) begin
                rdata_d = ctrl_q[i];
            end
        end
        if (word_idx == IDX_CYCLES) begin
            rdata_d = cycles_q;
        end
        if (word_idx == IDX_STICKY) begin
            rdata_d = 32'(sticky_q);
        end
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                ctrl_q[i] <= '0;
            end
            cycles_q <= '0;
            sticky_q <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            strobe_q <= '0;
        end else begin
            ctrl_q   <= ctrl_d;
            cycles_q <= cycles_d;
            sticky_q <= sticky_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            strobe_q <= strobe_d;
        end
    end

    for (genvar g = 0; g < NREGS; g++) begin : g_ctrl_out
        assign ctrl_out[32*g +: 32] = ctrl_q[g];
    end

    assign readdata      = rdata_q;
    assign readdatavalid = rvalid_q;
    assign wr_strobe     = strobe_q;

endmodule
